// File: rtl/lfsr_pkg.sv
// Shared constants for the 33-bit pseudorandom generator and its checker.
package lfsr_pkg;

  // Feedback tap pair of the generator (bit positions within the word).
  localparam int TAP_HI = 12;
  localparam int TAP_LO = 11;

  // Generator reset seed; its low 32 bits are the first observed word.
  localparam logic [32:0] SEED_33 = 33'h142C4E446;

  // Checker state encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/lfsr_next.sv
// Combinational one-step prediction of the generator word:
// shift left by one and feed the tap XOR into bit 0.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_word,
  output logic [WIDTH-1:0] o_next
);

  logic w_fb;

  assign w_fb   = i_word[TAP_HI] ^ i_word[TAP_LO];
  // Whole-vector shift: the MSB falls off the top, exactly as in the generator.
  assign o_next = (i_word << 1) | {{(WIDTH-1){1'b0}}, w_fb};

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the pseudorandom generator stream.
// Predicts each valid word from the previous one, locks after LOCK_COUNT
// consecutive correct predictions, then flags and counts mismatches.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no reference word held; waiting for a non-zero word
// HUNT   | reference held; counting consecutive correct predictions
// LOCKED | stream tracked; a mismatch pulses err and bumps err_count
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LOCK_COUNT = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             err,
  output logic             zero_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int                RUN_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0]  LOCK_RUN = RUN_W'(LOCK_COUNT);

  state_t             r_state;
  logic [WIDTH-1:0]   r_ref;
  logic [RUN_W-1:0]   r_run;
  logic               r_locked;
  logic               r_err;
  logic               r_zero_err;
  logic [CNT_W-1:0]   r_err_count;

  logic [WIDTH-1:0]   w_pred;
  logic               w_zero;
  logic               w_match;
  logic [RUN_W-1:0]   w_run_inc;
  logic               w_cnt_full;

  lfsr_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .i_word (r_ref),
    .o_next (w_pred)
  );

  assign w_zero     = (in_data == '0);
  assign w_match    = (in_data == w_pred);
  // run never exceeds LOCK_COUNT-1 while hunting, so the increment cannot wrap.
  assign w_run_inc  = r_run + 1'b1;
  assign w_cnt_full = (r_err_count == {CNT_W{1'b1}});

  // Checker FSM with reference word, match run, error counter and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ref       <= '0;
      r_run       <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_zero_err  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err      <= 1'b0;
      r_zero_err <= 1'b0;
      if (in_valid) begin
        case (r_state)
          IDLE: begin
            if (w_zero) begin
              r_zero_err <= 1'b1;
            end else begin
              r_ref   <= in_data;
              r_run   <= '0;
              r_state <= HUNT;
            end
          end
          HUNT: begin
            r_ref <= in_data;
            if (w_zero) begin
              r_zero_err <= 1'b1;
              r_run      <= '0;
              r_state    <= IDLE;
            end else if (w_match) begin
              r_run <= w_run_inc;
              if (w_run_inc == LOCK_RUN) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_run <= '0;
            end
          end
          LOCKED: begin
            r_ref <= in_data;
            if (w_zero) begin
              r_zero_err <= 1'b1;
              r_run      <= '0;
              r_state    <= IDLE;
              r_locked   <= 1'b0;
            end else if (!w_match) begin
              r_err    <= 1'b1;
              r_run    <= '0;
              r_state  <= HUNT;
              r_locked <= 1'b0;
              if (!w_cnt_full) begin
                r_err_count <= r_err_count + 1'b1;
              end
            end
          end
          default: begin
            r_state  <= IDLE;
            r_run    <= '0;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign err       = r_err;
  assign zero_err  = r_zero_err;
  assign err_count = r_err_count;

endmodule
